// File: rtl/decimal_value_entry.sv
// Keypad entry of a two-digit decimal preset (0..MAX_VALUE) committed with a one-cycle load strobe.
// Optional idle-timeout discard of partial entries is built when ENTRY_TIMEOUT_EN is defined.
module decimal_value_entry #(
  parameter int unsigned MAX_VALUE      = 99,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [6:0] value,
  output logic       load,
  output logic       err,
  output logic       timeout,
  output logic [3:0] dig_units,
  output logic [3:0] dig_tens,
  output logic [1:0] entry_len
);

  // State encoding doubles as the digit count shown on entry_len.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam logic [3:0] KEY_LAST_DIGIT = 4'h9;
  localparam logic [3:0] KEY_CLEAR      = 4'hA;
  localparam logic [3:0] KEY_ENTER      = 4'hB;
  localparam logic [6:0] MAX_VALUE_7    = 7'(MAX_VALUE);

  state_e     state_q, state_d;
  logic [3:0] units_q, units_d;
  logic [3:0] tens_q, tens_d;
  logic [6:0] value_q, value_d;
  logic       load_q, load_d;
  logic       err_q, err_d;

  logic       key_acc;
  logic       key_digit;
  logic       key_enter;
  logic [6:0] tens_7;
  logic [6:0] entry_v;
  logic       expire;

  // Codes 0xC-0xF are not key events at all: they neither edit nor rearm the idle timer.
  assign key_acc   = key_valid && (key_code <= KEY_ENTER);
  assign key_digit = key_acc && (key_code <= KEY_LAST_DIGIT);
  assign key_enter = key_acc && (key_code == KEY_ENTER);

  // tens*10 as shift-and-add; digits are 0..9 so the result never exceeds 99.
  assign tens_7  = {3'b000, tens_q};
  assign entry_v = (tens_7 << 3) + (tens_7 << 1) + {3'b000, units_q};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    units_d = units_q;
    tens_d  = tens_q;
    value_d = value_q;
    load_d  = 1'b0;
    err_d   = 1'b0;

    if (key_acc) begin
      case (state_q)
        EMPTY: begin
          if (key_digit) begin
            units_d = key_code;
            tens_d  = 4'd0;
            state_d = ONE;
          end
        end
        ONE, TWO: begin
          if (key_digit) begin
            tens_d  = units_q;
            units_d = key_code;
            state_d = TWO;
          end else begin
            if (key_enter) begin
              if (entry_v <= MAX_VALUE_7) begin
                value_d = entry_v;
                load_d  = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end
            units_d = 4'd0;
            tens_d  = 4'd0;
            state_d = EMPTY;
          end
        end
        default: begin
          units_d = 4'd0;
          tens_d  = 4'd0;
          state_d = EMPTY;
        end
      endcase
    end else if (expire) begin
      units_d = 4'd0;
      tens_d  = 4'd0;
      state_d = EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      units_q <= 4'd0;
      tens_q  <= 4'd0;
      value_q <= 7'd0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      units_q <= units_d;
      tens_q  <= tens_d;
      value_q <= value_d;
      load_q  <= load_d;
      err_q   <= err_d;
    end
  end

`ifdef ENTRY_TIMEOUT_EN
  localparam int unsigned      IDLE_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);

  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              timeout_q;

  // A key in the expiry cycle rearms the timer instead of expiring.
  always_comb begin
    idle_d = idle_q;
    expire = 1'b0;
    if (key_acc || (state_q == EMPTY)) begin
      idle_d = '0;
    end else if (idle_q == IDLE_LAST) begin
      idle_d = '0;
      expire = 1'b1;
    end else begin
      idle_d = idle_q + IDLE_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= expire;
    end
  end

  assign timeout = timeout_q;
`else
  // Without the timer the parameter has no consumer; keep it referenced for lint.
  localparam int unsigned timeout_unused = TIMEOUT_CYCLES;

  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  assign value     = value_q;
  assign load      = load_q;
  assign err       = err_q;
  assign dig_units = units_q;
  assign dig_tens  = tens_q;
  assign entry_len = state_q;

endmodule

// File: tb/tb_decimal_value_entry.sv
// Self-checking bench for decimal_value_entry: directed key sequences then random keys,
// compared against a digit-queue reference model.
module tb_decimal_value_entry;

  localparam int unsigned MAXV = 50;
  localparam int unsigned TCYC = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [6:0] value;
  logic       load;
  logic       err;
  logic       timeout;
  logic [3:0] dig_units;
  logic [3:0] dig_tens;
  logic [1:0] entry_len;

  decimal_value_entry #(
    .MAX_VALUE      (MAXV),
    .TIMEOUT_CYCLES (TCYC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_code  (key_code),
    .value     (value),
    .load      (load),
    .err       (err),
    .timeout   (timeout),
    .dig_units (dig_units),
    .dig_tens  (dig_tens),
    .entry_len (entry_len)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: digits typed so far (oldest first), last committed value, strobes.
  int q[$];
  int m_value   = 0;
  int m_load    = 0;
  int m_err     = 0;
  int m_timeout = 0;
  int m_idle    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_value   = 0;
    m_load    = 0;
    m_err     = 0;
    m_timeout = 0;
    m_idle    = 0;
  endtask

  task automatic model_step(input logic v, input logic [3:0] c);
    int n;
    m_load    = 0;
    m_err     = 0;
    m_timeout = 0;
    if (v && c <= 4'hB) begin
      m_idle = 0;
      if (c <= 4'h9) begin
        q.push_back(int'(c));
        if (q.size() > 2) void'(q.pop_front());
      end else if (c == 4'hB && q.size() > 0) begin
        n = (q.size() == 1) ? q[0] : q[0] * 10 + q[1];
        if (n <= int'(MAXV)) begin
          m_value = n;
          m_load  = 1;
        end else begin
          m_err = 1;
        end
        q.delete();
      end else begin
        q.delete();
      end
    end else if (q.size() > 0) begin
`ifdef ENTRY_TIMEOUT_EN
      m_idle++;
      if (m_idle == int'(TCYC)) begin
        q.delete();
        m_idle    = 0;
        m_timeout = 1;
      end
`endif
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".value"},   32'(value),     32'(m_value));
    check({tag, ".load"},    32'(load),      32'(m_load));
    check({tag, ".err"},     32'(err),       32'(m_err));
    check({tag, ".timeout"}, 32'(timeout),   32'(m_timeout));
    check({tag, ".len"},     32'(entry_len), 32'(q.size()));
    check({tag, ".units"},   32'(dig_units), (q.size() > 0) ? 32'(q[q.size()-1]) : 32'd0);
    check({tag, ".tens"},    32'(dig_tens),  (q.size() > 1) ? 32'(q[0]) : 32'd0);
  endtask

  // One clock with an optional key; outputs sampled 1 time unit after the edge.
  task automatic tick(input string tag, input logic v, input logic [3:0] c);
    @(negedge clk);
    key_valid = v;
    key_code  = c;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    model_step(v, c);
    compare_all(tag);
  endtask

  task automatic press(input string tag, input logic [3:0] c);
    tick(tag, 1'b1, c);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag, 1'b0, 4'h0);
  endtask

  initial begin
    int r;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // 42 commits; length steps 1, 2, 0 and load is a single pulse.
    press("k4", 4'h4);
    press("k2", 4'h2);
    press("ent42", 4'hB);
    check("ent42.const", 32'(value), 32'd42);
    idle("after42", 1);

    // Single digit then ENTER alone on an empty entry.
    press("k7", 4'h7);
    press("ent7", 4'hB);
    press("ent_empty", 4'hB);
    check("ent_empty.noload", 32'(load), 32'd0);

    // Shift drops the oldest digit: 1,2,3 -> 23.
    press("k1", 4'h1);
    press("k2b", 4'h2);
    press("k3", 4'h3);
    press("ent23", 4'hB);
    check("ent23.const", 32'(value), 32'd23);

    // Out of range (60 > 50): error, value held.
    press("k6", 4'h6);
    press("k0", 4'h0);
    press("ent60", 4'hB);
    check("ent60.err", 32'(err), 32'd1);
    check("ent60.hold", 32'(value), 32'd23);

    // Boundary: 50 commits, 51 errors.
    press("k5a", 4'h5);
    press("k0a", 4'h0);
    press("ent50", 4'hB);
    press("k5b", 4'h5);
    press("k1b", 4'h1);
    press("ent51", 4'hB);

    // CLEAR mid-entry, ignored code mid-entry, then commit 5.
    press("k9", 4'h9);
    press("clr", 4'hA);
    press("k5c", 4'h5);
    press("ignE", 4'hE);
    press("ent5", 4'hB);
    check("ent5.const", 32'(value), 32'd5);

`ifdef ENTRY_TIMEOUT_EN
    // Partial entry discarded after TCYC idle cycles.
    press("k3t", 4'h3);
    idle("wait_to", int'(TCYC) - 1);
    check("pre_to.len", 32'(entry_len), 32'd1);
    idle("expire", 1);
    check("expire.timeout", 32'(timeout), 32'd1);
    idle("post_to", 1);
    // Key arriving in the expiry cycle wins.
    press("k2t", 4'h2);
    idle("near_to", int'(TCYC) - 1);
    press("k8t", 4'h8);
    check("key_wins.len", 32'(entry_len), 32'd2);
    press("clr_t", 4'hA);
`else
    // Without the timer a partial entry is held indefinitely.
    press("k3t", 4'h3);
    idle("hold", 20);
    check("hold.len", 32'(entry_len), 32'd1);
    press("clr_t", 4'hA);
`endif

    // Asynchronous reset mid-entry discards everything.
    press("k8", 4'h8);
    press("k1r", 4'h1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all("rst_mid");
    @(negedge clk);
    reset = 1'b0;

    // Random key stream, weighted towards digits, with occasional idle gaps.
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 11));
      if (r < 6)       press("rnd_dig", 4'($urandom_range(0, 9)));
      else if (r == 6) press("rnd_ent", 4'hB);
      else if (r == 7) press("rnd_clr", 4'hA);
      else if (r == 8) press("rnd_ign", 4'($urandom_range(12, 15)));
      else if (r == 9) idle("rnd_gap", int'($urandom_range(1, 12)));
      else             idle("rnd_idle", 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
